idea_block_packer: RTL and testbench

Upstream feeder for the IDEA datapath. Accepts a byte stream under a valid/ready handshake and assembles each group of 8 bytes into the 64-bit `text` block the cipher consumes. When encrypting, it applies PKCS#5 padding at end of message. It holds each block stable under its own valid/ready handshake until the cipher side takes it.

---
 rtl/idea_block_packer_if.sv | 40 ++++
 rtl/idea_block_packer.sv | 149 ++++++++++++++
 tb/tb_idea_block_packer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/idea_block_packer_if.sv
// rtl/idea_block_packer_if.sv - byte-in / block-out handshake bundle for idea_block_packer
//
// Signals:
//   din[0:7]      upstream byte (bit 0 is the MSB)
//   din_valid     din/din_last valid
//   din_last      current byte ends the message
//   din_ready     packer accepts a byte this cycle
//   pad_en        1 = encrypt (PKCS#5 padding), 0 = decrypt
//   text[0:63]    assembled block, first byte in [0:7]
//   text_valid    text holds a complete block
//   text_ready    downstream takes the block
//   text_last     block is the final block of the message
//   pad_err       sticky: partial final block seen while pad_en=0
//
// Modports:
//   slave  - the packer (slave of the byte stream, source of blocks)
//   master - the surrounding environment (byte source, block sink)

interface idea_block_packer_if;
  logic [0:7]  din;
  logic        din_valid;
  logic        din_last;
  logic        din_ready;
  logic        pad_en;
  logic [0:63] text;
  logic        text_valid;
  logic        text_ready;
  logic        text_last;
  logic        pad_err;

  modport slave (
    input  din, din_valid, din_last, pad_en, text_ready,
    output din_ready, text, text_valid, text_last, pad_err
  );

  modport master (
    output din, din_valid, din_last, pad_en, text_ready,
    input  din_ready, text, text_valid, text_last, pad_err
  );
endinterface

// File: rtl/idea_block_packer.sv
// rtl/idea_block_packer.sv - packs a byte stream into 64-bit IDEA blocks with PKCS#5 padding
//
// Ports:
//   clk  in   single clock, rising edge
//   rst  in   asynchronous active-high reset
//   bus  slave modport of idea_block_packer_if (byte stream in, block stream out,
//        sticky pad_err)
//
// Bytes are written into the block register at position cnt while in FILL.
// A full block moves straight to OUT; a short final block spends one cycle in
// PAD where all remaining byte lanes are filled in parallel. A message whose
// length is a multiple of 8 in encrypt mode gets an extra all-0x08 block,
// generated by revisiting PAD from OUT with pad_val=8 and cnt=0.

module idea_block_packer (
  input logic               clk,
  input logic               rst,
  idea_block_packer_if.slave bus
);

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_PAD  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t      r_state;
  logic [2:0]  r_cnt;
  logic [0:63] r_text;
  logic [3:0]  r_pad_val;
  logic        r_pad_pending;
  logic        r_text_last;
  logic        r_pad_err;
  logic        r_pad_en;

  state_t      w_state_nxt;
  logic [2:0]  w_cnt_nxt;
  logic [0:63] w_text_nxt;
  logic [3:0]  w_pad_val_nxt;
  logic        w_pad_pending_nxt;
  logic        w_text_last_nxt;
  logic        w_pad_err_nxt;
  logic        w_pad_en_nxt;
  logic [7:0]  w_pad_byte;

  // Handshake flags depend only on state, so upstream/downstream see no
  // combinational path through the packer.
  assign bus.din_ready  = (r_state == S_FILL);
  assign bus.text_valid = (r_state == S_OUT);
  assign bus.text       = r_text;
  assign bus.text_last  = r_text_last;
  assign bus.pad_err    = r_pad_err;

  // Decrypt mode never invents pad bytes; lanes are zeroed instead.
  assign w_pad_byte = r_pad_en ? {4'b0000, r_pad_val} : 8'h00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_FILL;
      r_cnt         <= 3'd0;
      r_text        <= 64'd0;
      r_pad_val     <= 4'd0;
      r_pad_pending <= 1'b0;
      r_text_last   <= 1'b0;
      r_pad_err     <= 1'b0;
      r_pad_en      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_text        <= w_text_nxt;
      r_pad_val     <= w_pad_val_nxt;
      r_pad_pending <= w_pad_pending_nxt;
      r_text_last   <= w_text_last_nxt;
      r_pad_err     <= w_pad_err_nxt;
      r_pad_en      <= w_pad_en_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_text_nxt        = r_text;
    w_pad_val_nxt     = r_pad_val;
    w_pad_pending_nxt = r_pad_pending;
    w_text_last_nxt   = r_text_last;
    w_pad_err_nxt     = r_pad_err;
    w_pad_en_nxt      = r_pad_en;

    case (r_state)
      S_FILL: begin
        if (bus.din_valid) begin
          w_text_nxt[{r_cnt, 3'b000} +: 8] = bus.din;
          w_cnt_nxt    = r_cnt + 3'd1;
          // pad_en is captured with every byte; PAD uses the value seen
          // alongside the last byte.
          w_pad_en_nxt = bus.pad_en;
          if (r_cnt == 3'd7) begin
            w_state_nxt = S_OUT;
            if (bus.din_last && bus.pad_en) begin
              w_text_last_nxt   = 1'b0;
              w_pad_pending_nxt = 1'b1;
            end else begin
              w_text_last_nxt = bus.din_last;
            end
          end else if (bus.din_last) begin
            w_state_nxt   = S_PAD;
            w_pad_val_nxt = 4'd7 - {1'b0, r_cnt};
          end
        end
      end

      S_PAD: begin
        // r_cnt already points past the last data byte, so lanes
        // r_cnt..7 are exactly the unfilled ones.
        for (int i = 0; i < 8; i++) begin
          if (3'(i) >= r_cnt) begin
            w_text_nxt[8*i +: 8] = w_pad_byte;
          end
        end
        if (!r_pad_en) begin
          w_pad_err_nxt = 1'b1;
        end
        w_cnt_nxt       = 3'd0;
        w_text_last_nxt = 1'b1;
        w_state_nxt     = S_OUT;
      end

      S_OUT: begin
        if (bus.text_ready) begin
          w_cnt_nxt = 3'd0;
          if (r_pad_pending) begin
            // Full final block in encrypt mode: emit a whole block of 0x08.
            w_pad_pending_nxt = 1'b0;
            w_pad_val_nxt     = 4'd8;
            w_state_nxt       = S_PAD;
          end else begin
            w_text_last_nxt = 1'b0;
            w_state_nxt     = S_FILL;
          end
        end
      end

      default: begin
        w_state_nxt = S_FILL;
      end
    endcase
  end

endmodule

// File: tb/tb_idea_block_packer.sv
// tb/tb_idea_block_packer.sv - randomized self-checking bench for idea_block_packer

module tb_idea_block_packer;

  logic clk;
  logic rst;

  idea_block_packer_if bus ();

  idea_block_packer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit m_err    = 1'b0;

  logic [63:0] exp_blk[$];
  bit          exp_last[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: split message into 8-byte blocks; PKCS#5 pads a short tail with
  // (8 - tail) copies of that count, or adds a whole 0x08 block after a full
  // tail. Decrypt mode zero-fills a short tail and adds nothing.
  task automatic build_model(input logic [7:0] msg[$], input bit pe);
    int n, nb, k;
    logic [63:0] blk;
    logic [7:0]  b;
    exp_blk.delete();
    exp_last.delete();
    n  = msg.size();
    nb = (n + 7) / 8;
    for (int bi = 0; bi < nb; bi++) begin
      blk = 64'd0;
      for (int j = 0; j < 8; j++) begin
        k = bi * 8 + j;
        if (k < n) b = msg[k];
        else       b = pe ? 8'(8 * nb - n) : 8'h00;
        blk = {blk[55:0], b};
      end
      exp_blk.push_back(blk);
      exp_last.push_back((bi == nb - 1) && !(pe && (n % 8 == 0)));
    end
    if (pe && (n % 8 == 0)) begin
      exp_blk.push_back(64'h0808080808080808);
      exp_last.push_back(1'b1);
    end
    if (!pe && (n % 8 != 0)) m_err = 1'b1;
  endtask

  // hold < 0: text_ready always 1; hold == 0: random; hold > 0: held low for
  // that many cycles of text_valid, then raised.
  task automatic run_msg(input logic [7:0] msg[$], input bit pe, input int vpct, input int hold);
    int idx, nblk, vcyc;
    bit acc, xfer, pv_held, done;
    logic [63:0] gt, pv_text;
    bit gl;
    build_model(msg, pe);
    idx = 0; nblk = 0; vcyc = 0; pv_held = 0; done = 0; pv_text = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (idx == msg.size() && nblk == exp_blk.size()) begin
        done = 1;
        break;
      end
      @(negedge clk);
      bus.din_valid = (idx < msg.size()) && ($urandom_range(99) < vpct);
      bus.din       = (idx < msg.size()) ? msg[idx] : 8'($urandom);
      bus.din_last  = (idx == msg.size() - 1);
      bus.pad_en    = pe;
      if (bus.text_valid) vcyc++; else vcyc = 0;
      if (hold < 0)      bus.text_ready = 1'b1;
      else if (hold > 0) bus.text_ready = (vcyc > hold);
      else               bus.text_ready = ($urandom_range(99) < 50);
      if (pv_held) begin
        check("hold_valid", bus.text_valid, 1);
        check("hold_stable", bus.text, pv_text);
      end
      if (bus.text_valid) check("din_ready_in_out", bus.din_ready, 0);
      acc  = bus.din_valid && bus.din_ready;
      xfer = bus.text_valid && bus.text_ready;
      gt   = bus.text;
      gl   = bus.text_last;
      pv_held = bus.text_valid && !xfer;
      pv_text = gt;
      @(posedge clk);
      if (acc) idx++;
      if (xfer) begin
        if (nblk < exp_blk.size()) begin
          check("block", gt, exp_blk[nblk]);
          check("block_last", gl, exp_last[nblk]);
        end else begin
          check("extra_block", 1, 0);
        end
        nblk++;
      end
    end
    if (!done) check("timeout", 1, 0);
    @(negedge clk);
    bus.din_valid  = 1'b0;
    bus.text_ready = 1'b0;
    check("pad_err", bus.pad_err, m_err);
  endtask

  logic [7:0] m[$];

  initial begin
    rst = 1'b1;
    bus.din = 8'h00; bus.din_valid = 1'b0; bus.din_last = 1'b0;
    bus.pad_en = 1'b0; bus.text_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_text", bus.text, 64'd0);
    check("rst_text_valid", bus.text_valid, 0);
    check("rst_din_ready", bus.din_ready, 1);
    check("rst_text_last", bus.text_last, 0);
    check("rst_pad_err", bus.pad_err, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_din_ready", bus.din_ready, 1);

    m = {}; for (int i = 1; i <= 8; i++) m.push_back(8'(i));
    run_msg(m, 1, 100, -1);

    m = {8'hAA, 8'hBB, 8'hCC};
    run_msg(m, 1, 100, -1);
    m = {8'hAA, 8'hBB, 8'hCC};
    run_msg(m, 0, 100, -1);

    m = {}; for (int i = 0; i < 16; i++) m.push_back(8'(i));
    run_msg(m, 0, 100, 5);

    // Single byte: PAD on the cycle after acceptance, block visible 2 edges on.
    @(negedge clk);
    bus.din = 8'h7F; bus.din_valid = 1'b1; bus.din_last = 1'b1; bus.pad_en = 1'b1;
    bus.text_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.din_valid = 1'b0;
    check("lat_pad_cycle_valid", bus.text_valid, 0);
    check("lat_pad_cycle_ready", bus.din_ready, 0);
    @(posedge clk);
    @(negedge clk);
    check("lat_valid", bus.text_valid, 1);
    check("lat_text", bus.text, 64'h7F07070707070707);
    check("lat_last", bus.text_last, 1);
    bus.text_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.text_ready = 1'b0;
    check("lat_back_to_fill", bus.din_ready, 1);
    check("pad_err_sticky", bus.pad_err, m_err);

    // Reset mid-fill discards the partial block immediately.
    for (int i = 0; i < 5; i++) begin
      bus.din = 8'hE0 + 8'(i); bus.din_valid = 1'b1; bus.din_last = 1'b0; bus.pad_en = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    bus.din_valid = 1'b0;
    check("pre_rst_text_nonzero", (bus.text != 64'd0), 1);
    rst = 1'b1;
    #1;
    check("async_rst_text", bus.text, 64'd0);
    check("async_rst_valid", bus.text_valid, 0);
    check("async_rst_pad_err", bus.pad_err, 0);
    m_err = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m = {}; for (int i = 0; i < 8; i++) m.push_back(8'h11 + 8'(i));
    run_msg(m, 0, 100, -1);

    for (int t = 0; t < 25; t++) begin
      int len;
      len = $urandom_range(20, 1);
      m = {};
      for (int i = 0; i < len; i++) m.push_back(8'($urandom));
      run_msg(m, 1'($urandom_range(1)), $urandom_range(100, 30), $urandom_range(3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
